// File: rtl/breakout_pkg.sv
// Shared breakout constants and the hit-resolver state type.
package breakout_pkg;
  localparam int GRID_COLS  = 12;
  localparam int GRID_ROWS  = 7;
  localparam int NUM_BLOCKS = 84;
  localparam int MEM_DEPTH  = 128;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_READ  = 2'd2,
    ST_CHECK = 2'd3
  } res_state_e;
endpackage

// File: rtl/block_addr_calc.sv
// Maps a pixel position onto a block column, row and memory address.
module block_addr_calc
  import breakout_pkg::*;
#(
  parameter int FIELD_X      = 64,
  parameter int FIELD_Y      = 48,
  parameter int BLOCK_W_LOG2 = 5,
  parameter int BLOCK_H_LOG2 = 4
) (
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  output logic [3:0] col_o,
  output logic [2:0] row_o,
  output logic [6:0] addr_o,
  output logic       out_of_field_o
);
  logic [9:0] dx, dy, col_full, row_full;
  logic       oof;

  assign dx       = x_i - 10'(FIELD_X);
  assign dy       = y_i - 10'(FIELD_Y);
  assign col_full = dx >> BLOCK_W_LOG2;
  assign row_full = dy >> BLOCK_H_LOG2;

  // Left/top checks guard against the wrapped subtraction results.
  assign oof = (x_i < 10'(FIELD_X)) || (y_i < 10'(FIELD_Y)) ||
               (col_full >= 10'(GRID_COLS)) || (row_full >= 10'(GRID_ROWS));

  assign out_of_field_o = oof;
  assign col_o  = oof ? 4'd0 : col_full[3:0];
  assign row_o  = oof ? 3'd0 : row_full[2:0];
  assign addr_o = ({4'd0, row_o} << 3) + ({4'd0, row_o} << 2) + {3'd0, col_o};
endmodule

// File: rtl/block_hit_resolver.sv
// Resolves ball hit queries against the block-state memory, clearing hit
// blocks, tracking the live count and refilling the field on reset/new level.
module block_hit_resolver
  import breakout_pkg::*;
#(
  parameter int FIELD_X      = 64,
  parameter int FIELD_Y      = 48,
  parameter int BLOCK_W_LOG2 = 5,
  parameter int BLOCK_H_LOG2 = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic [9:0] REQ_X,
  input  logic [9:0] REQ_Y,
  output logic       RSP_VALID,
  output logic       RSP_HIT,
  output logic [3:0] RSP_COL,
  output logic [2:0] RSP_ROW,
  input  logic       LEVEL_START,
  output logic [6:0] BLOCKS_LEFT,
  output logic       LEVEL_CLEAR,
  output logic [6:0] MEM_ADDR,
  output logic       MEM_WE,
  output logic       MEM_DIN,
  input  logic       MEM_DOUT
);
  res_state_e state_q, state_d;
  logic [6:0] cnt_q, cnt_d, addr_q, addr_d, blocks_q, blocks_d;
  logic [3:0] col_q, col_d, rsp_col_q, rsp_col_d;
  logic [2:0] row_q, row_d, rsp_row_q, rsp_row_d;
  logic       oof_q, oof_d, pend_q, pend_d;
  logic       rsp_valid_q, rsp_valid_d, rsp_hit_q, rsp_hit_d, hit;

  logic [3:0] calc_col;
  logic [2:0] calc_row;
  logic [6:0] calc_addr;
  logic       calc_oof;

  block_addr_calc #(
    .FIELD_X(FIELD_X), .FIELD_Y(FIELD_Y),
    .BLOCK_W_LOG2(BLOCK_W_LOG2), .BLOCK_H_LOG2(BLOCK_H_LOG2)
  ) u_calc (
    .x_i(REQ_X), .y_i(REQ_Y), .col_o(calc_col), .row_o(calc_row),
    .addr_o(calc_addr), .out_of_field_o(calc_oof)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_FILL;
      cnt_q       <= '0;
      addr_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      oof_q       <= 1'b0;
      pend_q      <= 1'b0;
      blocks_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_col_q   <= '0;
      rsp_row_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      col_q       <= col_d;
      row_q       <= row_d;
      oof_q       <= oof_d;
      pend_q      <= pend_d;
      blocks_q    <= blocks_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_col_q   <= rsp_col_d;
      rsp_row_q   <= rsp_row_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    col_d       = col_q;
    row_d       = row_q;
    oof_d       = oof_q;
    pend_d      = pend_q;
    blocks_d    = blocks_q;
    rsp_valid_d = 1'b0;
    rsp_hit_d   = rsp_hit_q;
    rsp_col_d   = rsp_col_q;
    rsp_row_d   = rsp_row_q;
    hit         = 1'b0;
    REQ_READY   = 1'b0;
    MEM_WE      = 1'b0;
    MEM_ADDR    = addr_q;
    MEM_DIN     = 1'b0;
    case (state_q)
      ST_FILL: begin
        MEM_WE   = 1'b1;
        MEM_ADDR = cnt_q;
        MEM_DIN  = (cnt_q < 7'(NUM_BLOCKS));
        pend_d   = 1'b0;
        if (LEVEL_START) begin
          cnt_d = '0;
        end else if (cnt_q == 7'(MEM_DEPTH - 1)) begin
          cnt_d    = '0;
          blocks_d = 7'(NUM_BLOCKS);
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      ST_IDLE: begin
        // A new or deferred level start wins over any query this cycle.
        if (LEVEL_START || pend_q) begin
          state_d = ST_FILL;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else begin
          REQ_READY = 1'b1;
          if (REQ_VALID) begin
            addr_d  = calc_addr;
            col_d   = calc_col;
            row_d   = calc_row;
            oof_d   = calc_oof;
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (LEVEL_START) pend_d = 1'b1;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (LEVEL_START) pend_d = 1'b1;
        hit         = !oof_q && MEM_DOUT;
        MEM_WE      = hit;
        rsp_valid_d = 1'b1;
        rsp_hit_d   = hit;
        rsp_col_d   = col_q;
        rsp_row_d   = row_q;
        if (hit && blocks_q != 7'd0) blocks_d = blocks_q - 7'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_FILL;
    endcase
  end

  assign RSP_VALID   = rsp_valid_q;
  assign RSP_HIT     = rsp_hit_q;
  assign RSP_COL     = rsp_col_q;
  assign RSP_ROW     = rsp_row_q;
  assign BLOCKS_LEFT = blocks_q;
  assign LEVEL_CLEAR = (state_q == ST_IDLE) && (blocks_q == 7'd0);
endmodule

// File: tb/tb_block_hit_resolver.sv
// Directed bench for block_hit_resolver with a 128x1 registered-read memory model.
module tb_block_hit_resolver;
  logic       CLK = 1'b0;
  logic       RESET_N = 1'b1;
  logic       REQ_VALID = 1'b0;
  logic       REQ_READY;
  logic [9:0] REQ_X = '0;
  logic [9:0] REQ_Y = '0;
  logic       RSP_VALID, RSP_HIT;
  logic [3:0] RSP_COL;
  logic [2:0] RSP_ROW;
  logic       LEVEL_START = 1'b0;
  logic [6:0] BLOCKS_LEFT;
  logic       LEVEL_CLEAR;
  logic [6:0] MEM_ADDR;
  logic       MEM_WE, MEM_DIN;
  logic       mem_dout;

  logic       mem [0:127];
  int         wr_cnt = 0;
  int         rsp_cnt = 0;
  logic [6:0] last_wa = '0;
  logic       last_wd = 1'b0;

  int compared = 0;
  int mismatched = 0;

  block_hit_resolver dut (
    .CLK(CLK), .RESET_N(RESET_N), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_X(REQ_X), .REQ_Y(REQ_Y), .RSP_VALID(RSP_VALID), .RSP_HIT(RSP_HIT),
    .RSP_COL(RSP_COL), .RSP_ROW(RSP_ROW), .LEVEL_START(LEVEL_START),
    .BLOCKS_LEFT(BLOCKS_LEFT), .LEVEL_CLEAR(LEVEL_CLEAR), .MEM_ADDR(MEM_ADDR),
    .MEM_WE(MEM_WE), .MEM_DIN(MEM_DIN), .MEM_DOUT(mem_dout)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (MEM_WE) begin
      mem[MEM_ADDR] <= MEM_DIN;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= MEM_ADDR;
      last_wd <= MEM_DIN;
    end
    mem_dout <= mem[MEM_ADDR];
    if (RSP_VALID) rsp_cnt <= rsp_cnt + 1;
  end

  // Called in the first FILL cycle (counter 0), sampled at a negedge.
  task automatic fill_check(input string tag);
    int snap;
    int ones;
    snap = wr_cnt;
    for (int i = 0; i < 128; i++) begin
      compared++;
      if (MEM_WE !== 1'b1 || MEM_ADDR !== 7'(i) || MEM_DIN !== (i < 84)) begin
        mismatched++;
        $display("FAIL %s fill[%0d]: we=%b addr=%0d din=%b, required we=1 addr=%0d din=%0d",
                 tag, i, MEM_WE, MEM_ADDR, MEM_DIN, i, (i < 84));
      end
      @(negedge CLK);
    end
    compared++;
    if (wr_cnt - snap !== 128) begin
      mismatched++; $display("FAIL %s fill_writes: got %0d required 128", tag, wr_cnt - snap);
    end
    compared++;
    if (REQ_READY !== 1'b1) begin
      mismatched++; $display("FAIL %s ready_after_fill: got %b required 1", tag, REQ_READY);
    end
    compared++;
    if (BLOCKS_LEFT !== 7'd84) begin
      mismatched++; $display("FAIL %s blocks_after_fill: got %0d required 84", tag, BLOCKS_LEFT);
    end
    ones = 0;
    for (int a = 0; a < 84; a++) if (mem[a] === 1'b1) ones++;
    for (int a = 84; a < 128; a++) if (mem[a] !== 1'b0) ones += 1000;
    compared++;
    if (ones !== 84) begin
      mismatched++; $display("FAIL %s mem_contents: score %0d required 84", tag, ones);
    end
  endtask

  // Issues one query from a negedge in IDLE; returns at the RSP_VALID negedge.
  task automatic query(input logic [9:0] x, input logic [9:0] y,
                       output int lat, output int wrs);
    int snap;
    REQ_X = x; REQ_Y = y; REQ_VALID = 1'b1;
    snap = wr_cnt;
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    lat = 1;
    while (RSP_VALID !== 1'b1 && lat < 10) begin
      @(negedge CLK);
      lat++;
    end
    wrs = wr_cnt - snap;
  endtask

  task automatic test_reset();
    #1 RESET_N = 1'b0;
    @(negedge CLK);
    compared++;
    if ({REQ_READY, RSP_VALID, RSP_HIT, RSP_COL, RSP_ROW, BLOCKS_LEFT, LEVEL_CLEAR} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: rdy=%b rv=%b hit=%b col=%0d row=%0d bl=%0d lc=%b, required all 0",
               REQ_READY, RSP_VALID, RSP_HIT, RSP_COL, RSP_ROW, BLOCKS_LEFT, LEVEL_CLEAR);
    end
    compared++;
    if (MEM_WE !== 1'b1 || MEM_ADDR !== 7'd0 || MEM_DIN !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_mem: we=%b addr=%0d din=%b, required 1/0/1", MEM_WE, MEM_ADDR, MEM_DIN);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    fill_check("post_reset");
  endtask

  task automatic test_hit_basic();
    int lat, wrs;
    query(10'd64, 10'd48, lat, wrs);
    compared++;
    if (lat !== 3 || RSP_HIT !== 1'b1 || RSP_COL !== 4'd0 || RSP_ROW !== 3'd0) begin
      mismatched++;
      $display("FAIL first_hit: lat=%0d hit=%b col=%0d row=%0d, required 3/1/0/0", lat, RSP_HIT, RSP_COL, RSP_ROW);
    end
    compared++;
    if (wrs !== 1 || last_wa !== 7'd0 || last_wd !== 1'b0 || mem[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL first_hit_write: n=%0d addr=%0d din=%b, required 1 write addr 0 din 0", wrs, last_wa, last_wd);
    end
    compared++;
    if (BLOCKS_LEFT !== 7'd83) begin
      mismatched++; $display("FAIL first_hit_blocks: got %0d required 83", BLOCKS_LEFT);
    end
    query(10'd64, 10'd48, lat, wrs);
    compared++;
    if (lat !== 3 || RSP_HIT !== 1'b0 || wrs !== 0 || BLOCKS_LEFT !== 7'd83) begin
      mismatched++;
      $display("FAIL repeat_miss: lat=%0d hit=%b writes=%0d bl=%0d, required 3/0/0/83", lat, RSP_HIT, wrs, BLOCKS_LEFT);
    end
  endtask

  task automatic test_corners();
    int lat, wrs;
    query(10'd447, 10'd159, lat, wrs);
    compared++;
    if (lat !== 3 || RSP_HIT !== 1'b1 || RSP_COL !== 4'd11 || RSP_ROW !== 3'd6) begin
      mismatched++;
      $display("FAIL corner_hit: lat=%0d hit=%b col=%0d row=%0d, required 3/1/11/6", lat, RSP_HIT, RSP_COL, RSP_ROW);
    end
    compared++;
    if (wrs !== 1 || last_wa !== 7'd83 || last_wd !== 1'b0 || BLOCKS_LEFT !== 7'd82) begin
      mismatched++;
      $display("FAIL corner_write: n=%0d addr=%0d din=%b bl=%0d, required 1/83/0/82", wrs, last_wa, last_wd, BLOCKS_LEFT);
    end
    query(10'd448, 10'd100, lat, wrs);
    compared++;
    if (lat !== 3 || RSP_HIT !== 1'b0 || RSP_COL !== 4'd0 || RSP_ROW !== 3'd0 || wrs !== 0) begin
      mismatched++;
      $display("FAIL oof_right: lat=%0d hit=%b col=%0d row=%0d wr=%0d, required 3/0/0/0/0", lat, RSP_HIT, RSP_COL, RSP_ROW, wrs);
    end
    query(10'd63, 10'd100, lat, wrs);
    compared++;
    if (lat !== 3 || RSP_HIT !== 1'b0 || RSP_COL !== 4'd0 || RSP_ROW !== 3'd0 || wrs !== 0 || BLOCKS_LEFT !== 7'd82) begin
      mismatched++;
      $display("FAIL oof_left: lat=%0d hit=%b col=%0d row=%0d wr=%0d bl=%0d, required 3/0/0/0/0/82",
               lat, RSP_HIT, RSP_COL, RSP_ROW, wrs, BLOCKS_LEFT);
    end
  endtask

  task automatic test_clear_all();
    int lat, wrs;
    logic exp_hit;
    for (int r = 0; r < 7; r++) begin
      for (int c = 0; c < 12; c++) begin
        query(10'(64 + 32 * c), 10'(48 + 16 * r), lat, wrs);
        exp_hit = !((r == 0 && c == 0) || (r == 6 && c == 11));
        compared++;
        if (lat !== 3 || RSP_HIT !== exp_hit || RSP_COL !== 4'(c) || RSP_ROW !== 3'(r)) begin
          mismatched++;
          $display("FAIL sweep r%0d c%0d: lat=%0d hit=%b col=%0d row=%0d, required 3/%b/%0d/%0d",
                   r, c, lat, RSP_HIT, RSP_COL, RSP_ROW, exp_hit, c, r);
        end
      end
    end
    compared++;
    if (BLOCKS_LEFT !== 7'd0 || LEVEL_CLEAR !== 1'b1) begin
      mismatched++;
      $display("FAIL level_clear: bl=%0d lc=%b, required 0/1", BLOCKS_LEFT, LEVEL_CLEAR);
    end
    LEVEL_START = 1'b1;
    @(negedge CLK);
    LEVEL_START = 1'b0;
    compared++;
    if (LEVEL_CLEAR !== 1'b0) begin
      mismatched++; $display("FAIL level_clear_drop: got %b required 0", LEVEL_CLEAR);
    end
    fill_check("level_start");
  endtask

  task automatic test_start_with_req();
    int snap;
    snap = rsp_cnt;
    REQ_X = 10'd96; REQ_Y = 10'd48; REQ_VALID = 1'b1; LEVEL_START = 1'b1;
    #1;
    compared++;
    if (REQ_READY !== 1'b0) begin
      mismatched++; $display("FAIL start_vs_req_ready: got %b required 0", REQ_READY);
    end
    @(negedge CLK);
    REQ_VALID = 1'b0; LEVEL_START = 1'b0;
    fill_check("start_vs_req");
    compared++;
    if (rsp_cnt !== snap) begin
      mismatched++; $display("FAIL start_vs_req_rsp: got %0d responses required 0", rsp_cnt - snap);
    end
  endtask

  task automatic test_start_in_check();
    REQ_X = 10'd64; REQ_Y = 10'd48; REQ_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    @(negedge CLK);
    LEVEL_START = 1'b1;
    @(negedge CLK);
    LEVEL_START = 1'b0;
    compared++;
    if (RSP_VALID !== 1'b1 || RSP_HIT !== 1'b1 || BLOCKS_LEFT !== 7'd83 || REQ_READY !== 1'b0) begin
      mismatched++;
      $display("FAIL start_in_check_rsp: rv=%b hit=%b bl=%0d rdy=%b, required 1/1/83/0",
               RSP_VALID, RSP_HIT, BLOCKS_LEFT, REQ_READY);
    end
    @(negedge CLK);
    fill_check("start_in_check");
  endtask

  task automatic test_reset_in_check();
    int lat, wrs;
    query(10'd96, 10'd64, lat, wrs);
    compared++;
    if (lat !== 3 || RSP_HIT !== 1'b1 || RSP_COL !== 4'd1 || RSP_ROW !== 3'd1 || last_wa !== 7'd13) begin
      mismatched++;
      $display("FAIL pre_reset_hit: lat=%0d hit=%b col=%0d row=%0d addr=%0d, required 3/1/1/1/13",
               lat, RSP_HIT, RSP_COL, RSP_ROW, last_wa);
    end
    REQ_X = 10'd128; REQ_Y = 10'd64; REQ_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    @(negedge CLK);
    compared++;
    if (MEM_WE !== 1'b1 || MEM_ADDR !== 7'd14 || MEM_DIN !== 1'b0) begin
      mismatched++;
      $display("FAIL check_write_pending: we=%b addr=%0d din=%b, required 1/14/0", MEM_WE, MEM_ADDR, MEM_DIN);
    end
    RESET_N = 1'b0;
    #1;
    compared++;
    if ({REQ_READY, RSP_VALID, RSP_HIT, RSP_COL, RSP_ROW, BLOCKS_LEFT, LEVEL_CLEAR} !== '0 ||
        MEM_WE !== 1'b1 || MEM_ADDR !== 7'd0 || MEM_DIN !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_mid: rdy=%b rv=%b col=%0d row=%0d bl=%0d we=%b addr=%0d din=%b, required reset values",
               REQ_READY, RSP_VALID, RSP_COL, RSP_ROW, BLOCKS_LEFT, MEM_WE, MEM_ADDR, MEM_DIN);
    end
    @(negedge CLK);
    compared++;
    if (mem[14] !== 1'b1) begin
      mismatched++; $display("FAIL reset_dropped_write: mem[14]=%b required 1", mem[14]);
    end
    RESET_N = 1'b1;
    fill_check("reset_refill");
  endtask

  initial begin
    test_reset();
    test_hit_basic();
    test_corners();
    test_clear_all();
    test_start_with_req();
    test_start_in_check();
    test_reset_in_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/block_hit_resolver.md
# block_hit_resolver

Collision front-end for the breakout block field. It takes ball-position hit queries from the game logic and maps each one to a block address. It reads and clears the block through the block-state memory's read/write port, and reports hit or miss together with the remaining block count. It also refills the whole memory on reset and on each new level. The renderer keeps its own read-only port and is unaffected.

## Interface

Parameters:
- FIELD_X, 64: left pixel edge of block field.
- FIELD_Y, 48: top pixel edge of block field.
- BLOCK_W_LOG2, 5: block width 32 px.
- BLOCK_H_LOG2, 4: block height 16 px.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- REQ_VALID  in  1  hit query valid.
- REQ_READY  out  1  resolver can accept a query.
- REQ_X  in  10  ball probe x (unsigned px).
- REQ_Y  in  10  ball probe y (unsigned px).
- RSP_VALID  out  1  one-cycle response strobe.
- RSP_HIT  out  1  block was present and has been cleared.
- RSP_COL  out  4  column of the query (0 on out-of-field).
- RSP_ROW  out  3  row of the query (0 on out-of-field).
- LEVEL_START  in  1  pulse: refill field.
- BLOCKS_LEFT  out  7  live block count.
- LEVEL_CLEAR  out  1  BLOCKS_LEFT==0 while IDLE.
- MEM_ADDR  out  7  to memory port A address.
- MEM_WE  out  1  to port A write enable.
- MEM_DIN  out  1  to port A write data.
- MEM_DOUT  in  1  from port A registered read data (1-cycle read latency).

## Operation

- Grid: 12 cols × 7 rows = 84 blocks. Address = row*12 + col, computed as (row<<3)+(row<<2)+col. Memory depth 128. Addresses 84..127 are always 0.
- Mapping: col = (X−FIELD_X)>>BLOCK_W_LOG2, row = (Y−FIELD_Y)>>BLOCK_H_LOG2. The query is out-of-field if X<FIELD_X, Y<FIELD_Y, col≥12 or row≥7. Out-of-field queries never access memory.
- States:
  - FILL: writes every address 0..127, one per cycle, with MEM_WE=1 and MEM_DIN=(addr<84). After address 127, BLOCKS_LEFT←84 and go to IDLE.
  - IDLE: REQ_READY=1. If LEVEL_START is high, go to FILL with counter 0; this takes priority over REQ_VALID, and REQ_READY is combinationally 0 that cycle. Otherwise, if REQ_VALID is high, latch the address, col, row and out-of-field flag, then go to READ.
  - READ: present MEM_ADDR; no write. Go to CHECK.
  - CHECK: MEM_DOUT is valid. If in-field and MEM_DOUT=1, assert MEM_WE=1 and MEM_DIN=0 at the same address. Go to IDLE. At that edge, register RSP_VALID=1 and RSP_HIT, and decrement BLOCKS_LEFT on a hit (saturating at 0).
- LEVEL_START in READ or CHECK is latched as pending. FILL starts on the first IDLE cycle, before any new query is accepted. LEVEL_START in FILL restarts the counter at 0.
- RSP_COL and RSP_ROW hold their last value until the next response.

## Timing

- Reset values: state FILL, fill counter 0, REQ_READY 0, RSP_VALID 0, RSP_HIT 0, RSP_COL 0, RSP_ROW 0, BLOCKS_LEFT 0, LEVEL_CLEAR 0, MEM_WE 1 (the fill begins immediately), MEM_ADDR 0, MEM_DIN 1.
- Reset asserted mid-operation aborts at once. Any pending write is dropped and pending LEVEL_START is cleared. Refill restarts after RESET_N deasserts.
- The post-reset fill takes 128 cycles. REQ_READY rises on cycle 129.
- Query latency:
  - Query accepted at edge T0.
  - MEM_ADDR valid from T0.
  - MEM_DOUT valid after edge T1.
  - Clearing write occurs in the cycle after T1, committed at edge T2.
  - RSP_VALID is high for the cycle following T2.
  - This latency is identical for hit, miss and out-of-field queries.
- Throughput: one query per 3 cycles. REQ_READY is low in READ and CHECK.
- The updated BLOCKS_LEFT is visible in the same cycle as RSP_VALID.
- MEM_WE is never high outside FILL or a CHECK hit.

## Structure

- Shared package breakout_pkg holds:
  - GRID_COLS=12, GRID_ROWS=7, NUM_BLOCKS=84, MEM_DEPTH=128.
  - The resolver state enum (FILL, IDLE, READ, CHECK).
- One combinational sub-module, block_addr_calc: takes X and Y plus the parameters and produces col, row, addr and out_of_field. The renderer reuses it.

## Test plan

- Reset then release: exactly 128 write cycles, addr 0..83 written 1 and 84..127 written 0. Then BLOCKS_LEFT=84 and REQ_READY=1.
- Query X=64, Y=48: RSP_VALID 3 cycles after acceptance with HIT=1, COL=0, ROW=0, and address 0 written 0; BLOCKS_LEFT=83. Repeat the query: HIT=0, no MEM_WE, BLOCKS_LEFT stays 83.
- Queries X=447,Y=159 (HIT, COL=11, ROW=6, addr 83), then X=448,Y=100 and X=63,Y=100 (HIT=0, COL=0, ROW=0, no memory write). All three have latency 3.
- Clear all 84 blocks: LEVEL_CLEAR=1 after the final response. Pulse LEVEL_START: LEVEL_CLEAR drops, 128-cycle fill runs, then BLOCKS_LEFT=84.
- LEVEL_START in the same cycle as REQ_VALID in IDLE: query is not accepted and FILL starts. LEVEL_START during CHECK: the response completes, then FILL starts.
- RESET_N asserted during the CHECK cycle of a hit: no write to memory, all outputs at reset values, fill restarts from address 0.
